// File: rtl/ram_pkg.sv
// ram_pkg: shared controller state encoding, default geometry and latency, counter sizing.
//   Used by ram_ctrl (state type, counter width, defaults) and ram_array (default geometry).
package ram_pkg;

  localparam int defRamWidth  = 8;
  localparam int defAddrWidth = 8;
  localparam int defLatency   = 3;
  localparam int cntWidth     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } ctrlState;

  // The counter starts one below the latency because the WAIT edge that
  // sees zero is itself the access edge.
  function automatic logic [cntWidth-1:0] loadCount(input int lat);
    return cntWidth'(lat - 1);
  endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: 2**addrWidth x ramWidth synchronous single-port storage, no reset.
//   clk | we: write wrData to addr | re: load rdData from addr | rdData: registered read data
module ram_array
  import ram_pkg::*;
#(
  parameter int ramWidth  = defRamWidth,
  parameter int addrWidth = defAddrWidth
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [addrWidth-1:0] addr,
  input  logic [ramWidth-1:0]  wrData,
  output logic [ramWidth-1:0]  rdData
);

  logic [ramWidth-1:0] mem [2**addrWidth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wrData;
    if (re) rdData <= mem[addr];
  end

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: main-memory controller behind the cache, one word access per four-phase syn/ack handshake.
//   clk, clr (async, active-low)
//   syn, readWrite, addr, dataIn: request from cache, sampled together in IDLE
//   dataOut, ack: completion back to cache; ack held until syn drops
//   busy: state is not IDLE | protoErr: sticky, syn seen low while waiting
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int ramWidth  = defRamWidth,
  parameter int addrWidth = defAddrWidth,
  parameter int latency   = defLatency
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 syn,
  input  logic                 readWrite,
  input  logic [addrWidth-1:0] addr,
  input  logic [ramWidth-1:0]  dataIn,
  output logic [ramWidth-1:0]  dataOut,
  output logic                 ack,
  output logic                 busy,
  output logic                 protoErr
);

  ctrlState             state;
  logic [cntWidth-1:0]  cnt;
  logic                 rwQ;
  logic [addrWidth-1:0] addrQ;
  logic [ramWidth-1:0]  dataQ;
  logic [ramWidth-1:0]  rdData;
  logic                 haveData;
  logic                 access;

  // The array fires on the same edge that moves WAIT to ACK, so its
  // registered read data lands together with ack.
  assign access = (state == WAIT) && (cnt == '0);
  assign busy   = state != IDLE;
  // The array has no reset; until a read completes after reset, show zero.
  assign dataOut = haveData ? rdData : '0;

  ram_array #(
    .ramWidth (ramWidth),
    .addrWidth(addrWidth)
  ) array (
    .clk   (clk),
    .we    (access && rwQ),
    .re    (access && !rwQ),
    .addr  (addrQ),
    .wrData(dataQ),
    .rdData(rdData)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= '0;
      ack      <= 1'b0;
      protoErr <= 1'b0;
      haveData <= 1'b0;
      rwQ      <= 1'b0;
      addrQ    <= '0;
      dataQ    <= '0;
    end else begin
      case (state)
        IDLE: if (syn) begin
          rwQ   <= readWrite;
          addrQ <= addr;
          dataQ <= dataIn;
          cnt   <= loadCount(latency);
          state <= WAIT;
        end
        WAIT: begin
          // An early syn drop is flagged but the access still completes.
          if (!syn) protoErr <= 1'b1;
          if (cnt != '0) cnt <= cnt - cntWidth'(1);
          else begin
            ack   <= 1'b1;
            state <= ACK;
            if (!rwQ) haveData <= 1'b1;
          end
        end
        ACK: if (!syn) begin
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: self-checking bench for ram_ctrl (latency 3 and latency 1 builds) against a memory-array model.
module tb_ram_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic syn0 = 1'b0, syn1 = 1'b0, readWrite = 1'b0;
  logic [7:0] addr = 8'h00, dataIn = 8'h00;
  logic [7:0] dataOut0, dataOut1;
  logic ack0, ack1, busy0, busy1, perr0, perr1;
  int tests = 0, fails = 0;
  logic [7:0] model [256];
  bit known [256];
  logic [7:0] lastQ = 8'h00;

  always #5 clk = ~clk;

  ram_ctrl #(.ramWidth(8), .addrWidth(8), .latency(3)) dut (
    .clk(clk), .clr(clr), .syn(syn0), .readWrite(readWrite), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut0), .ack(ack0), .busy(busy0), .protoErr(perr0)
  );

  ram_ctrl #(.ramWidth(8), .addrWidth(8), .latency(1)) dut1 (
    .clk(clk), .clr(clr), .syn(syn1), .readWrite(readWrite), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut1), .ack(ack1), .busy(busy1), .protoErr(perr1)
  );

  // One full handshake; after the sample edge the request lines are scrambled
  // to prove only latched values are used. Returns edges from sample to ack
  // (-1 on timeout), dataOut at ack, ack one edge after syn drops, busy cycles.
  task automatic ramOp(input bit sel, input bit rw, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] sa, input logic [7:0] sd,
                       output int lat, output logic [7:0] q, output logic ackAfter, output int busyCnt);
    @(posedge clk); #1;
    if (sel) syn1 = 1'b1; else syn0 = 1'b1;
    readWrite = rw; addr = a; dataIn = d;
    @(posedge clk); #1;
    readWrite = ~rw; addr = sa; dataIn = sd;
    lat = -1;
    q = 'x;
    busyCnt = (sel ? busy1 : busy0) ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (sel ? busy1 : busy0) busyCnt++;
      if (sel ? ack1 : ack0) begin
        lat = i;
        q = sel ? dataOut1 : dataOut0;
        break;
      end
    end
    syn0 = 1'b0; syn1 = 1'b0;
    @(posedge clk); #1;
    ackAfter = sel ? ack1 : ack0;
    if (sel ? busy1 : busy0) busyCnt++;
  endtask

  task automatic test_reset;
    #2 clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", ack0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy0); end
    tests++; if (perr0 !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", perr0); end
    tests++; if (dataOut0 !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", dataOut0); end
    tests++; if ({ack1, busy1, perr1, dataOut1} !== 11'h0) begin fails++; $display("FAIL reset_lat1: got %b%b%b %h want all 0", ack1, busy1, perr1, dataOut1); end
    clr = 1'b1;
    lastQ = 8'h00;
  endtask

  task automatic test_write_read;
    int lat, bc; logic [7:0] q; logic aa;
    ramOp(0, 1, 8'h3A, 8'hC5, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    model[8'h3A] = 8'hC5; known[8'h3A] = 1;
    tests++; if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", lat); end
    tests++; if (aa !== 1'b0) begin fails++; $display("FAIL wr_ack_fall: got %b want 0", aa); end
    tests++; if (bc !== 4) begin fails++; $display("FAIL wr_busy_cycles: got %0d want 4", bc); end
    tests++; if (q !== lastQ) begin fails++; $display("FAIL wr_dataout_kept: got %h want %h", q, lastQ); end
    ramOp(0, 0, 8'h3A, 8'h00, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    lastQ = 8'hC5;
    tests++; if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d want 3", lat); end
    tests++; if (q !== 8'hC5) begin fails++; $display("FAIL rd_3A: got %h want c5", q); end
    tests++; if (dataOut0 !== 8'hC5) begin fails++; $display("FAIL rd_hold_after_ack: got %h want c5", dataOut0); end
  endtask

  task automatic test_boundaries;
    int lat, bc; logic [7:0] q; logic aa;
    ramOp(0, 1, 8'h00, 8'h11, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    ramOp(0, 1, 8'hFF, 8'hEE, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    model[8'h00] = 8'h11; known[8'h00] = 1;
    model[8'hFF] = 8'hEE; known[8'hFF] = 1;
    ramOp(0, 0, 8'h00, 8'h00, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    tests++; if (q !== 8'h11) begin fails++; $display("FAIL rd_addr00: got %h want 11", q); end
    ramOp(0, 0, 8'hFF, 8'h00, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    tests++; if (q !== 8'hEE) begin fails++; $display("FAIL rd_addrFF: got %h want ee", q); end
    lastQ = 8'hEE;
  endtask

  task automatic test_instability;
    int lat, bc; logic [7:0] q; logic aa;
    ramOp(0, 1, 8'h55, 8'h3C, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    ramOp(0, 1, 8'h20, 8'h9D, 8'h55, 8'hAA, lat, q, aa, bc);
    model[8'h55] = 8'h3C; model[8'h20] = 8'h9D; known[8'h55] = 1; known[8'h20] = 1;
    ramOp(0, 0, 8'h20, 8'h00, 8'h55, 8'hAA, lat, q, aa, bc);
    tests++; if (q !== 8'h9D) begin fails++; $display("FAIL instab_20: got %h want 9d", q); end
    ramOp(0, 0, 8'h55, 8'h00, 8'h20, 8'hAA, lat, q, aa, bc);
    tests++; if (q !== 8'h3C) begin fails++; $display("FAIL instab_55: got %h want 3c", q); end
    lastQ = 8'h3C;
  endtask

  task automatic test_random;
    int lat, bc, badLat = 0, badData = 0, badAck = 0; logic [7:0] q, a, d; logic aa; bit rw;
    for (int n = 0; n < 40; n++) begin
      a = 8'h90 | 8'($urandom_range(0, 15));
      d = 8'($urandom);
      rw = $urandom_range(0, 1) == 1 || !known[a];
      ramOp(0, rw, a, d, 8'($urandom), 8'($urandom), lat, q, aa, bc);
      if (lat != 3 || bc != 4) badLat++;
      if (aa !== 1'b0) badAck++;
      if (rw) begin
        if (q !== lastQ) badData++;
        model[a] = d; known[a] = 1;
      end else begin
        if (q !== model[a]) badData++;
        lastQ = model[a];
      end
    end
    tests++; if (badLat != 0) begin fails++; $display("FAIL rand_timing: got %0d bad want 0", badLat); end
    tests++; if (badData != 0) begin fails++; $display("FAIL rand_data: got %0d bad want 0", badData); end
    tests++; if (badAck != 0) begin fails++; $display("FAIL rand_ack_fall: got %0d bad want 0", badAck); end
  endtask

  task automatic test_abort;
    int lat, bc, hi = 0; logic [7:0] q; logic aa;
    @(posedge clk); #1;
    syn0 = 1'b1; readWrite = 1'b1; addr = 8'h81; dataIn = 8'h6B;
    @(posedge clk); #1;
    @(posedge clk); #1;
    syn0 = 1'b0; addr = 8'h00; dataIn = 8'h00;
    @(posedge clk); #1;
    tests++; if (perr0 !== 1'b1) begin fails++; $display("FAIL abort_perr_set: got %b want 1", perr0); end
    tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL abort_ack_early: got %b want 0", ack0); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack0) hi++;
    end
    model[8'h81] = 8'h6B; known[8'h81] = 1;
    tests++; if (hi != 1) begin fails++; $display("FAIL abort_ack_pulse: got %0d cycles want 1", hi); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL abort_idle: got %b want 0", busy0); end
    ramOp(0, 0, 8'h81, 8'h00, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    tests++; if (q !== 8'h6B) begin fails++; $display("FAIL abort_write_done: got %h want 6b", q); end
    tests++; if (perr0 !== 1'b1) begin fails++; $display("FAIL abort_perr_sticky: got %b want 1", perr0); end
    @(posedge clk); #1;
    clr = 1'b0;
    #2;
    tests++; if (perr0 !== 1'b0) begin fails++; $display("FAIL abort_perr_clear: got %b want 0", perr0); end
    @(posedge clk); #1;
    clr = 1'b1;
    lastQ = 8'h00;
  endtask

  task automatic test_reset_mid;
    int lat, bc; logic [7:0] q; logic aa;
    ramOp(0, 1, 8'h40, 8'h12, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    model[8'h40] = 8'h12; known[8'h40] = 1;
    @(posedge clk); #1;
    syn0 = 1'b1; readWrite = 1'b1; addr = 8'h40; dataIn = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL rstmid_ack: got %b want 0", ack0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
    syn0 = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    ramOp(0, 0, 8'h40, 8'h00, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    tests++; if (q !== 8'h12) begin fails++; $display("FAIL rstmid_write_dropped: got %h want 12", q); end
    @(posedge clk); #1;
    syn0 = 1'b1; readWrite = 1'b0; addr = 8'h40;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    tests++; if (dataOut0 !== 8'h00) begin fails++; $display("FAIL rstmid_read_nodata: got %h want 00", dataOut0); end
    syn0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++; if (dataOut0 !== 8'h00 || ack0 !== 1'b0) begin fails++; $display("FAIL rstmid_read_quiet: got %h/%b want 00/0", dataOut0, ack0); end
    clr = 1'b1;
    lastQ = 8'h00;
  endtask

  task automatic test_latency1;
    int lat, bc; logic [7:0] q; logic aa;
    ramOp(1, 1, 8'h07, 8'h5A, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    tests++; if (lat !== 1) begin fails++; $display("FAIL lat1_wr_latency: got %0d want 1", lat); end
    ramOp(1, 0, 8'h07, 8'h00, 8'($urandom), 8'($urandom), lat, q, aa, bc);
    tests++; if (lat !== 1) begin fails++; $display("FAIL lat1_rd_latency: got %0d want 1", lat); end
    tests++; if (q !== 8'h5A) begin fails++; $display("FAIL lat1_rd_data: got %h want 5a", q); end
    tests++; if (bc !== 2) begin fails++; $display("FAIL lat1_busy_cycles: got %0d want 2", bc); end
    tests++; if (aa !== 1'b0) begin fails++; $display("FAIL lat1_ack_fall: got %b want 0", aa); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL lat1_other_idle: got %b want 0", busy0); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_boundaries;
    test_instability;
    test_random;
    test_abort;
    test_reset_mid;
    test_latency1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Main-memory controller sitting directly downstream of the direct-mapped cache. It accepts one word-wide read or write per four-phase syn/ack handshake, models a fixed access latency, and returns read data with the acknowledge. The cache's RAM-side outputs (address, data, read/write, syn) drive this block. Its data and ack outputs return to the cache's RAM-side inputs.

## Interface
- ramWidth, 8: data word width in bits.
- addrWidth, 8: word address width; memory depth is 2**addrWidth words.
- latency, 3: cycles from syn sample to ack; legal range 1..15.
- clk  in  1  single clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- syn  in  1  request strobe from cache; high opens a transaction.
- readWrite  in  1  0 = read, 1 = write; sampled with syn.
- addr  in  addrWidth  word address; sampled with syn.
- dataIn  in  ramWidth  write data; sampled with syn.
- dataOut  out  ramWidth  read data; valid while ack high on a read.
- ack  out  1  transaction complete; held until syn drops.
- busy  out  1  high whenever state is not IDLE.
- protoErr  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: on an edge with syn=1:
  - Latch readWrite, addr and dataIn.
  - Load the down-counter with latency-1.
  - Go to WAIT.
- WAIT:
  - If the counter is nonzero, decrement it.
  - If the counter is 0, perform the access, set ack=1 and go to ACK.
  - A write stores the latched data at the latched address.
  - A read loads dataOut from the latched address.
- ACK:
  - Hold ack and dataOut.
  - On an edge with syn=0, clear ack and go to IDLE.
  - dataOut keeps its last value after ack falls.
- Write transactions do not change dataOut.
- Access uses only the latched values. addr, dataIn or readWrite changing after the sample edge has no effect.
- Abort: if syn=0 is sampled while in WAIT, set protoErr=1. The access still completes and ack still asserts. Because syn is already low, the ACK state exits on the next edge, so ack is high for exactly 1 cycle.
- protoErr is cleared only by reset.
- Address wrap: none needed; every addrWidth-bit value is a valid word.
- Memory contents are not affected by reset, so block RAM can be inferred. Reading an unwritten word returns an undefined value.

## Timing
- Reset values: state IDLE, counter 0, ack 0, dataOut 0, busy 0, protoErr 0.
- Let E0 be the edge that samples syn=1 in IDLE. ack rises at edge E0+latency.
  - latency=1 gives IDLE→WAIT→ACK with no decrement.
- busy rises at E0 and falls at the edge where ack falls. busy is decoded combinationally from state.
- ack falls at the first edge in ACK that samples syn=0.
- Earliest next request: syn is sampled in IDLE one edge after ack falls. The cache must observe ack=0 before raising syn again.
- Reset asserted mid-transaction:
  - Go immediately to IDLE and clear ack.
  - A pending write is discarded; memory is unchanged.
  - A read in progress produces no data.
- Throughput: at most one transaction per latency+2 cycles.

## Structure
- Shared package `ram_pkg`:
  - State encoding: IDLE=2'b00, WAIT=2'b01, ACK=2'b10.
  - Default ramWidth, addrWidth and latency constants.
  - Counter width: 4 bits.
- Sub-module `ram_array`:
  - Parameterised 2**addrWidth × ramWidth storage.
  - Synchronous write enable.
  - Synchronous read into a registered output.
  - No reset.
  - ram_ctrl instantiates it, drives we/re in the WAIT-to-ACK transition cycle, and feeds the registered output to dataOut.

## Test plan
- Write then read, latency=3:
  - syn, readWrite=1, addr=0x3A, dataIn=0xC5 → ack rises 3 edges after sample; drop syn → ack falls next edge.
  - Then read 0x3A → dataOut=0xC5 when ack rises.
- Address boundaries: write 0x11 to 0x00 and 0xEE to 0xFF, then read both → 0x11 and 0xEE; neither word is aliased.
- latency=1 build: read request → ack at E0+1, busy high for exactly 2 cycles with syn dropped immediately after ack.
- Input instability: change addr and dataIn to 0x55/0xAA one cycle after the sample edge of a write to 0x20 → memory[0x20] holds the original data and 0x55 is unchanged.
- Abort: drop syn two cycles into WAIT → protoErr=1, ack pulses for 1 cycle, protoErr stays set until clr=0.
- Reset mid-WAIT of a write of 0x77 to 0x40 (0x40 previously holding 0x12) → ack=0 and busy=0 immediately; later read of 0x40 returns 0x12.
